// File: rtl/alu_operand_fetch.sv
// rtl/alu_operand_fetch.sv - issue stage: decode, register file, scoreboard, bypass, registered operand output
module alu_operand_fetch #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [2:0]       rd_tag,
  input  logic             wb_en,
  input  logic [2:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic             illegal
);

  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b101;

  // Architectural state
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [NREGS-1:0] pending_q, pending_d;

  // Output register
  logic             out_valid_q, out_valid_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       rd_tag_q, rd_tag_d;
  logic             illegal_q, illegal_d;

  // Decoded fields
  logic [2:0]       opcode, rd, rs, rt;
  logic [6:0]       imm7;
  logic [WIDTH-1:0] imm_sext;
  logic             is_addi, is_illegal, is_rtype;

  // Hazard / handshake
  logic             wb_hit_rs, wb_hit_rt, wb_hit_rd;
  logic             haz_rs, haz_rt, haz_rd, hazard;
  logic             out_free, accept, load;
  logic [WIDTH-1:0] rs_val, rt_val;
  logic [NREGS-1:0] wb_mask, set_mask;

  // Split the instruction word into fields and classify the opcode
  always_comb begin
    opcode     = instr[15:13];
    rd         = instr[12:10];
    rs         = instr[9:7];
    rt         = instr[6:4];
    imm7       = instr[6:0];
    imm_sext   = {{(WIDTH-7){imm7[6]}}, imm7};
    is_addi    = (opcode == OP_ADDI);
    is_illegal = opcode[2] & opcode[1];
    is_rtype   = ~is_addi & ~is_illegal;
  end

  // Operand read with same-cycle write-back bypass; R0 is hardwired to zero
  always_comb begin
    wb_hit_rs = wb_en && (wb_rd == rs);
    wb_hit_rt = wb_en && (wb_rd == rt);
    wb_hit_rd = wb_en && (wb_rd == rd);
    if (rs == 3'd0)     rs_val = '0;
    else if (wb_hit_rs) rs_val = wb_data;
    else                rs_val = rf_q[rs];
    if (rt == 3'd0)     rt_val = '0;
    else if (wb_hit_rt) rt_val = wb_data;
    else                rt_val = rf_q[rt];
  end

  // Scoreboard hazards: a pending register is only safe if its write-back lands this cycle
  always_comb begin
    haz_rs   = pending_q[rs] & ~wb_hit_rs;
    haz_rt   = is_rtype & pending_q[rt] & ~wb_hit_rt;
    haz_rd   = (rd != 3'd0) & pending_q[rd] & ~wb_hit_rd;
    hazard   = ~is_illegal & (haz_rs | haz_rt | haz_rd);
    out_free = ~out_valid_q | out_ready;
    in_ready = out_free & ~hazard;
    accept   = in_valid & in_ready;
    load     = accept & ~is_illegal;
  end

  // Next state: scoreboard update (set beats clear) and output register load
  always_comb begin
    wb_mask     = wb_en ? (NREGS'(1) << wb_rd) : '0;
    set_mask    = (load && (rd != 3'd0)) ? (NREGS'(1) << rd) : '0;
    pending_d   = (pending_q & ~wb_mask) | set_mask;
    out_valid_d = load | (out_valid_q & ~out_ready);
    illegal_d   = accept & is_illegal;
    alu_op_d    = alu_op_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_tag_d    = rd_tag_q;
    if (load) begin
      alu_op_d = is_addi ? OP_ADD : opcode;
      a_d      = rs_val;
      b_d      = is_addi ? imm_sext : rt_val;
      rd_tag_d = rd;
    end
  end

  // Output register, illegal pulse and scoreboard state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rd_tag_q    <= '0;
      illegal_q   <= 1'b0;
      pending_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rd_tag_q    <= rd_tag_d;
      illegal_q   <= illegal_d;
      pending_q   <= pending_d;
    end
  end

  // Register file write port; writes to R0 are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_rd != 3'd0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_op    = alu_op_q;
  assign a         = a_q;
  assign b         = b_q;
  assign rd_tag    = rd_tag_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// tb/tb_alu_operand_fetch.sv - directed vector bench for alu_operand_fetch
module tb_alu_operand_fetch;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] instr, a, b, wb_data;
  logic [2:0]  alu_op, rd_tag, wb_rd;
  logic        wb_en, illegal;

  int n_chk = 0;
  int n_err = 0;

  alu_operand_fetch #(.WIDTH(16), .NREGS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .a(a), .b(b), .rd_tag(rd_tag),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic [15:0] instr;
    logic        out_ready;
    logic        wb_en;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        e_ready;
    logic        e_valid;
    logic [2:0]  e_op;
    logic [15:0] e_a;
    logic [15:0] e_b;
    logic [2:0]  e_tag;
    logic        e_ill;
  } vec_t;

  vec_t tv[$];

  function automatic logic [15:0] r_ins(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 4'b0000};
  endfunction

  function automatic logic [15:0] i_ins(input logic [2:0] rd, input logic [2:0] rs,
                                        input logic [6:0] imm);
    return {3'b101, rd, rs, imm};
  endfunction

  task automatic add(input logic iv, input logic [15:0] ins, input logic ordy,
                     input logic we, input logic [2:0] wr, input logic [15:0] wd,
                     input logic er, input logic ev, input logic [2:0] eop,
                     input logic [15:0] ea, input logic [15:0] eb, input logic [2:0] etag,
                     input logic eil);
    vec_t v;
    v.in_valid = iv; v.instr = ins; v.out_ready = ordy;
    v.wb_en = we; v.wb_rd = wr; v.wb_data = wd;
    v.e_ready = er; v.e_valid = ev; v.e_op = eop; v.e_a = ea; v.e_b = eb;
    v.e_tag = etag; v.e_ill = eil;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] ins, input logic ordy,
                       input logic we, input logic [2:0] wr, input logic [15:0] wd);
    in_valid = iv; instr = ins; out_ready = ordy;
    wb_en = we; wb_rd = wr; wb_data = wd;
  endtask

  // check in_ready mid-cycle, then advance to just after the next rising edge
  task automatic step(input string nm, input logic er);
    @(negedge clk);
    chk({nm, ".in_ready"}, 32'(in_ready), 32'(er));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic ev, input logic [2:0] eop,
                         input logic [15:0] ea, input logic [15:0] eb, input logic [2:0] etag);
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(ev));
    if (ev) begin
      chk({nm, ".alu_op"}, 32'(alu_op), 32'(eop));
      chk({nm, ".a"},      32'(a),      32'(ea));
      chk({nm, ".b"},      32'(b),      32'(eb));
      chk({nm, ".rd_tag"}, 32'(rd_tag), 32'(etag));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 16'h0000, 1, 0, 0, 0);

    // iv  instr               ordy we rd data      rdy vld op  a         b         tag ill
    add(0, 16'h0000,          1, 1, 1, 16'h0005, 1, 0, 0, 0,        0,        0, 0);
    add(0, 16'h0000,          1, 1, 2, 16'h0003, 1, 0, 0, 0,        0,        0, 0);
    add(1, r_ins(2, 3, 1, 2), 1, 0, 0, 0,        1, 1, 2, 16'h0005, 16'h0003, 3, 0);
    add(1, r_ins(3, 4, 3, 1), 1, 0, 0, 0,        0, 0, 0, 0,        0,        0, 0);
    add(1, r_ins(3, 4, 3, 1), 1, 0, 0, 0,        0, 0, 0, 0,        0,        0, 0);
    add(1, r_ins(3, 4, 3, 1), 1, 0, 0, 0,        0, 0, 0, 0,        0,        0, 0);
    add(1, r_ins(3, 4, 3, 1), 1, 1, 3, 16'h1234, 1, 1, 3, 16'h1234, 16'h0005, 4, 0);
    add(1, i_ins(5, 0, 7'h7F),1, 0, 0, 0,        1, 1, 2, 16'h0000, 16'hFFFF, 5, 0);
    add(1, r_ins(2, 6, 0, 3), 1, 1, 0, 16'hBEEF, 1, 1, 2, 16'h0000, 16'h1234, 6, 0);
    add(1, r_ins(0, 7, 0, 0), 1, 0, 0, 0,        1, 1, 0, 16'h0000, 16'h0000, 7, 0);
    add(1, 16'hE000,          1, 0, 0, 0,        1, 0, 0, 0,        0,        0, 1);
    add(0, 16'h0000,          1, 0, 0, 0,        1, 0, 0, 0,        0,        0, 0);
    add(1, 16'hC400,          1, 0, 0, 0,        1, 0, 0, 0,        0,        0, 1);
    add(1, r_ins(2, 2, 1, 1), 1, 0, 0, 0,        1, 1, 2, 16'h0005, 16'h0005, 2, 0);
    add(1, r_ins(2, 5, 1, 1), 1, 0, 0, 0,        0, 0, 0, 0,        0,        0, 0);
    add(1, r_ins(2, 5, 1, 1), 1, 1, 5, 16'h0077, 1, 1, 2, 16'h0005, 16'h0005, 5, 0);
    add(1, r_ins(0, 1, 5, 0), 1, 0, 0, 0,        0, 0, 0, 0,        0,        0, 0);
    add(1, r_ins(0, 1, 5, 0), 1, 1, 5, 16'h00AA, 1, 1, 0, 16'h00AA, 16'h0000, 1, 0);
    add(1, r_ins(4, 3, 3, 5), 1, 0, 0, 0,        1, 1, 4, 16'h1234, 16'h00AA, 3, 0);
    add(1, r_ins(1, 0, 0, 2), 1, 0, 0, 0,        0, 0, 0, 0,        0,        0, 0);
    add(1, i_ins(0, 0, 7'h20),1, 0, 0, 0,        1, 1, 2, 16'h0000, 16'h0020, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.alu_op",    32'(alu_op),    0);
    chk("rst.a",         32'(a),         0);
    chk("rst.b",         32'(b),         0);
    chk("rst.rd_tag",    32'(rd_tag),    0);
    chk("rst.illegal",   32'(illegal),   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tv.size(); i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      drive(tv[i].in_valid, tv[i].instr, tv[i].out_ready,
            tv[i].wb_en, tv[i].wb_rd, tv[i].wb_data);
      step(nm, tv[i].e_ready);
      chk_out(nm, tv[i].e_valid, tv[i].e_op, tv[i].e_a, tv[i].e_b, tv[i].e_tag);
      chk({nm, ".illegal"}, 32'(illegal), 32'(tv[i].e_ill));
    end

    // backpressure: first op held while the ALU stalls, second loads as it is taken
    drive(0, 16'h0000, 1, 0, 0, 0);
    step("bp.drain", 1);
    chk_out("bp.drain", 0, 0, 0, 0, 0);
    drive(1, r_ins(2, 0, 5, 0), 0, 0, 0, 0);
    step("bp.first", 1);
    chk_out("bp.first", 1, 2, 16'h00AA, 16'h0000, 0);
    drive(1, r_ins(3, 0, 0, 5), 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      step($sformatf("bp.hold%0d", k), 0);
      chk_out($sformatf("bp.hold%0d", k), 1, 2, 16'h00AA, 16'h0000, 0);
    end
    drive(1, r_ins(3, 0, 0, 5), 1, 0, 0, 0);
    step("bp.second", 1);
    chk_out("bp.second", 1, 3, 16'h0000, 16'h00AA, 0);
    drive(0, 16'h0000, 1, 0, 0, 0);
    step("bp.empty", 1);
    chk_out("bp.empty", 0, 0, 0, 0, 0);

    // asynchronous reset while an output is held and R5 is pending
    drive(1, r_ins(2, 5, 5, 0), 0, 0, 0, 0);
    step("ar.load", 1);
    chk_out("ar.load", 1, 2, 16'h00AA, 16'h0000, 5);
    drive(0, 16'h0000, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar.out_valid", 32'(out_valid), 0);
    chk("ar.alu_op",    32'(alu_op),    0);
    chk("ar.a",         32'(a),         0);
    chk("ar.rd_tag",    32'(rd_tag),    0);
    rst_n = 1'b1;
    drive(1, r_ins(2, 1, 5, 3), 1, 0, 0, 0);
    step("ar.after", 1);
    chk_out("ar.after", 1, 2, 16'h0000, 16'h0000, 1);
    drive(1, r_ins(2, 0, 5, 0), 1, 1, 5, 16'h0042);
    step("ar.wb", 1);
    chk_out("ar.wb", 1, 2, 16'h0042, 16'h0000, 0);
    drive(1, r_ins(2, 0, 0, 5), 1, 0, 0, 0);
    step("ar.rf", 1);
    chk_out("ar.rf", 1, 2, 16'h0000, 16'h0042, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
